// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with a 2-entry skid buffer.
// Carries a PC, a control vector and a payload between two pipeline stages.
// in_ready comes from a flop, so a stalled downstream stage never creates a
// combinational ready path back up the pipe.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous kill of every held entry
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   in_pc/in_ctrl/in_data upstream entry
//   out_valid / out_ready downstream handshake
//   out_pc/out_ctrl/out_data registered entry; out_ctrl is 0 while out_valid=0
//   stall_cnt, flush_cnt  perf counters, present only with PIPE_PERF_CNT_EN
//
// Optional feature macro: PIPE_PERF_CNT_EN (stall/flush performance counters).
module pipe_stage_reg #(
  parameter int unsigned   DATA_W  = 64,
  parameter int unsigned   CTRL_W  = 16,
  parameter int unsigned   PC_W    = 32,
  parameter logic [PC_W-1:0] PC_INIT = PC_W'(32'h0000_0000),
  parameter int unsigned   CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;  // main invalid
  localparam logic [1:0] FULL  = 2'd1;  // main valid, skid invalid
  localparam logic [1:0] SKID  = 2'd2;  // main and skid valid

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     in_entry;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       in_fire_c, out_fire_c;

  // A zero-width counter is meaningless; nothing is generated for legal widths.
  if (CNT_W == 0) begin : g_cnt_w_invalid
  end

  assign in_entry.pc   = in_pc;
  assign in_entry.ctrl = in_ctrl;
  assign in_entry.data = in_data;

  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_q.pc    <= PC_INIT;
      main_q.ctrl  <= '0;
      main_q.data  <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and next-register logic; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (flush) begin
      // PC and payload hold; only the control vector is killed.
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      main_d.ctrl = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire_c) begin
            main_d      = in_entry;
            state_d     = FULL;
            out_valid_d = 1'b1;
          end
        end
        FULL: begin
          if (in_fire_c && out_fire_c) begin
            main_d = in_entry;
          end else if (in_fire_c) begin
            // in_ready was still high this cycle, so park the arrival.
            skid_d     = in_entry;
            state_d    = SKID;
            in_ready_d = 1'b0;
          end else if (out_fire_c) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
            main_d.ctrl = '0;
          end
        end
        SKID: begin
          if (out_fire_c) begin
            main_d     = skid_q;
            state_d    = FULL;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          state_d     = EMPTY;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          main_d.ctrl = '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = main_q.pc;
  assign out_ctrl  = main_q.ctrl;
  assign out_data  = main_q.data;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Stall: upstream offers an entry we cannot take. Flush counted only if it kills something.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_valid && !in_ready_q) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (state_q != EMPTY)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the stimulus side records every accepted
// entry in a FIFO model; a negedge monitor pops and compares on each out_fire.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned PC_W   = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam int unsigned CNT_W  = 4;
`else
  localparam int unsigned CNT_W  = 32;
`endif
  localparam logic [PC_W-1:0] PC_INIT = 32'h0000_1000;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  exp_t             q[$];
  int               checks;
  int               errors;
  int               pops;
  int               held_at_neg;
  logic             mon_en;
  logic             last_fire;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;
  logic [CNT_W-1:0] cnt_stall_edge;
  logic [CNT_W-1:0] cnt_flush_edge;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .PC_W   (PC_W),
    .PC_INIT(PC_INIT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is updated just after the negedge,
  // i.e. with the values the DUT will see at the next rising edge.
  task automatic cycle(input logic v, input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                       input logic [DATA_W-1:0] data, input logic ordy, input logic fl);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_ctrl   = ctrl;
    in_data   = data;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    last_fire      = in_valid && in_ready;
    cnt_stall_edge = exp_stall;
    cnt_flush_edge = exp_flush;
    if (in_valid && !in_ready) exp_stall = exp_stall + CNT_W'(1);
    if (flush) begin
      if (held_at_neg > 0) exp_flush = exp_flush + CNT_W'(1);
      q.delete();
    end else if (last_fire) begin
      e.pc   = in_pc;
      e.ctrl = in_ctrl;
      e.data = in_data;
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, '0, ordy, 1'b0);
  endtask

  // Monitor: handshake invariants derived from model occupancy, plus in-order data.
  always @(negedge clk) begin
    exp_t e;
    held_at_neg = q.size();
    if (mon_en && rst_n) begin
      chk("out_valid_vs_occupancy", 64'(out_valid), 64'(held_at_neg > 0));
      chk("in_ready_vs_occupancy", 64'(in_ready), 64'(held_at_neg < 2));
      if (!out_valid) chk("out_ctrl_zero_when_idle", 64'(out_ctrl), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc 0x%0h expected no entry at %0t", out_pc, $time);
        end else begin
          e = q.pop_front();
          pops++;
          chk("out_pc", 64'(out_pc), 64'(e.pc));
          chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
          chk("out_data", 64'(out_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    int pops_before;
    clk = 1'b0; rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_ctrl = '0; in_data = '0;
    checks = 0; errors = 0; pops = 0; held_at_neg = 0; mon_en = 1'b0; last_fire = 1'b0;
    exp_stall = '0; exp_flush = '0; cnt_stall_edge = '0; cnt_flush_edge = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'(PC_INIT));
`ifdef PIPE_PERF_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single entry, one-cycle latency
    cycle(1'b1, 32'h100, 16'h0005, 64'hA5, 1'b1, 1'b0);
    idle(1'b1);
    chk("lat1_out_valid", 64'(out_valid), 64'd1);
    chk("lat1_out_pc", 64'(out_pc), 64'h100);
    chk("lat1_out_ctrl", 64'(out_ctrl), 64'h5);
    chk("lat1_out_data", 64'(out_data), 64'hA5);
    chk("lat1_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);

    // Fill to SKID, third entry held off, then drain in order
    pops_before = pops;
    cycle(1'b1, 32'h100, 16'h0001, 64'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h104, 16'h0002, 64'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 16'h0003, 64'h33, 1'b0, 1'b0);
    chk("skid_in_ready_low", 64'(in_ready), 64'd0);
    chk("skid_third_held_off", 64'(last_fire), 64'd0);
    cycle(1'b1, 32'h108, 16'h0003, 64'h33, 1'b0, 1'b0);
    chk("skid_still_held_off", 64'(last_fire), 64'd0);
    begin
      int n;
      n = 0;
      do begin
        cycle(1'b1, 32'h108, 16'h0003, 64'h33, 1'b1, 1'b0);
        n++;
      end while (!last_fire && n < 10);
      chk("stream_third_accepted", 64'(last_fire), 64'd1);
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 10) begin
        idle(1'b1);
        n++;
      end
    end
    chk("stream_output_count", 64'(pops - pops_before), 64'd3);

    // Flush while in SKID; entry presented during flush is discarded
    cycle(1'b1, 32'h200, 16'h0007, 64'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h204, 16'h0008, 64'h204, 1'b0, 1'b0);
    cycle(1'b1, 32'h208, 16'h0009, 64'h208, 1'b0, 1'b0);
    cycle(1'b1, 32'h20C, 16'h000A, 64'h20C, 1'b0, 1'b1);
    idle(1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) idle(1'b1);
    // Flush while FULL with a simultaneous out_fire and discarded in_fire
    cycle(1'b1, 32'h300, 16'h0011, 64'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 16'h0012, 64'h304, 1'b1, 1'b1);
    repeat (3) idle(1'b1);

    // Asynchronous reset mid-cycle while FULL
    cycle(1'b1, 32'h400, 16'h0021, 64'h400, 1'b0, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2;
    chk("pre_reset_full", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_pc", 64'(out_pc), 64'(PC_INIT));
    chk("async_rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    exp_stall = '0;
    exp_flush = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Stall counter wrap and flush counter (counters checked only when compiled in)
    cycle(1'b1, 32'h500, 16'h0031, 64'h500, 1'b0, 1'b0);
    cycle(1'b1, 32'h504, 16'h0032, 64'h504, 1'b0, 1'b0);
    repeat (17) cycle(1'b1, 32'h508, 16'h0033, 64'h508, 1'b0, 1'b0);
    idle(1'b0);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt_model", 64'(stall_cnt), 64'(cnt_stall_edge));
    chk("stall_cnt_wrapped", 64'(stall_cnt), 64'd1);
`endif
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 32'h600, 16'h0041, 64'h600, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
`ifdef PIPE_PERF_CNT_EN
    chk("flush_cnt_model", 64'(flush_cnt), 64'(cnt_flush_edge));
    chk("flush_cnt_two", 64'(flush_cnt), 64'd2);
`endif

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), PC_W'($urandom), CTRL_W'($urandom),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
        idle(1'b1);
        n++;
      end
    end
    idle(1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("final_stall_cnt", 64'(stall_cnt), 64'(cnt_stall_edge));
    chk("final_flush_cnt", 64'(flush_cnt), 64'(cnt_flush_edge));
`endif

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
